// File: rtl/ahb_pkg.sv
// ahb_pkg: AHB-Lite encodings, response FSM states and burst helpers
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [2:0] HBURST_SINGLE = 3'd0;
  localparam logic [2:0] HBURST_INCR   = 3'd1;
  localparam logic [2:0] HBURST_WRAP4  = 3'd2;
  localparam logic [2:0] HBURST_INCR4  = 3'd3;
  localparam logic [2:0] HBURST_INCR8  = 3'd5;
  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_PUSH = 3'd1;
  localparam logic [2:0] ST_RD_PUSH = 3'd2;
  localparam logic [2:0] ST_RD_WAIT = 3'd3;
  localparam logic [2:0] ST_RD_DONE = 3'd4;
  localparam logic [2:0] ST_ERR1    = 3'd5;
  localparam logic [2:0] ST_ERR2    = 3'd6;
  function automatic logic [4:0] burst_beats(input logic [2:0] b);
    return b[2:1] == 2'b01 ? 5'd4 : b[2:1] == 2'b10 ? 5'd8 : b[2:1] == 2'b11 ? 5'd16 : 5'd0;
  endfunction
  function automatic logic is_wrap(input logic [2:0] b);
    return !b[0] && b != HBURST_SINGLE;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: in-order request queue; full/empty come from the registered occupancy
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign rdata = mem[rp];
  // pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  // storage needs no reset; only entries below level are ever observed
  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end
endmodule

// File: rtl/ahb_slave_if_fifo.sv
// ahb_slave_if_fifo: AHB-Lite slave front end queuing checked transfers toward the APB side
module ahb_slave_if_fifo
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          HSEL,
  input  logic [ADDR_W-1:0]             HADDR,
  input  logic                          HWRITE,
  input  logic [2:0]                    HSIZE,
  input  logic [2:0]                    HBURST,
  input  logic [1:0]                    HTRANS,
  input  logic                          HREADY,
  input  logic [DATA_W-1:0]             HWDATA,
  output logic                          HREADYOUT,
  output logic                          HRESP,
  output logic [DATA_W-1:0]             HRDATA,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic [ADDR_W-1:0]             req_addr,
  output logic [DATA_W-1:0]             req_wdata,
  output logic                          req_write,
  output logic [2:0]                    req_size,
  input  logic                          rsp_valid,
  input  logic [DATA_W-1:0]             rsp_rdata,
  input  logic                          rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic [2:0]        size;
  } req_t;
  logic [2:0] state, state_nx, size_r, burst_r, burst_sel;
  logic [ADDR_W-1:0] addr_r, exp_addr, step, win, incr_addr, nxt_addr;
  logic [4:0] beats_left;
  logic burst_open, ready, accept, seq, err, full, empty, push, st_wr;
  req_t push_req, head;
  assign ready = state == ST_IDLE || state == ST_RD_DONE || state == ST_ERR2 || (state == ST_WR_PUSH && !full);
  assign accept = ready && HSEL && HREADY && HTRANS[1];
  assign seq = HTRANS == HTRANS_SEQ;
  assign err = HSIZE > MAX_SIZE || (seq && (!burst_open || HADDR != exp_addr));
  assign burst_sel = seq ? burst_r : HBURST;
  assign step = ADDR_W'(1) << HSIZE;
  assign win = ADDR_W'(burst_beats(burst_sel)) << HSIZE;
  assign incr_addr = HADDR + step;
  assign nxt_addr = is_wrap(burst_sel) ? (HADDR & ~(win - 1'b1)) | (incr_addr & (win - 1'b1)) : incr_addr;
  assign HREADYOUT = ready;
  assign HRESP = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
  assign st_wr = state == ST_WR_PUSH;
  assign push = (st_wr || state == ST_RD_PUSH) && !full;
  assign push_req = '{addr_r, st_wr ? HWDATA : '0, st_wr, size_r};
  assign req_valid = !empty;
  assign {req_addr, req_wdata, req_write, req_size} = head;
  sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(HCLK),
    .rst(HRESET),
    .push(push),
    .pop(req_ready),
    .wdata(push_req),
    .rdata(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  // a completing data phase hands over to the next accepted address phase
  always_comb begin
    state_nx = state;
    if (ready) state_nx = accept ? (err ? ST_ERR1 : HWRITE ? ST_WR_PUSH : ST_RD_PUSH) : ST_IDLE;
    else if (state == ST_RD_PUSH) state_nx = full ? ST_RD_PUSH : ST_RD_WAIT;
    else if (state == ST_RD_WAIT && rsp_valid) state_nx = rsp_err ? ST_ERR1 : ST_RD_DONE;
    else if (state == ST_ERR1) state_nx = ST_ERR2;
  end
  // address-phase capture, burst tracking and read-data holding
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state <= ST_IDLE;
      addr_r <= '0;
      size_r <= '0;
      exp_addr <= '0;
      burst_r <= '0;
      beats_left <= '0;
      burst_open <= 1'b0;
      HRDATA <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_RD_WAIT && rsp_valid && !rsp_err) HRDATA <= rsp_rdata;
      if (accept) begin
        addr_r <= HADDR;
        size_r <= HSIZE;
        if (err) burst_open <= 1'b0;
        else if (!seq) begin
          burst_open <= HBURST != HBURST_SINGLE;
          burst_r <= HBURST;
          beats_left <= burst_beats(HBURST) - 5'd1;
          exp_addr <= nxt_addr;
        end else begin
          exp_addr <= nxt_addr;
          if (burst_r != HBURST_INCR) begin
            beats_left <= beats_left - 5'd1;
            burst_open <= beats_left != 5'd1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_ahb_slave_if_fifo.sv
// tb_ahb_slave_if_fifo: scoreboard bench with an AHB master, APB-side responder and pop monitor
module tb_ahb_slave_if_fifo;
  import ahb_pkg::*;
  logic HCLK = 1'b0;
  logic HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, req_valid, req_ready, req_write;
  logic rsp_valid, rsp_err, late_rsp, rsp_err_cfg;
  logic [31:0] HADDR, HWDATA, HRDATA, req_addr, req_wdata, rsp_rdata, rsp_data_cfg, rd;
  logic [2:0] HSIZE, HBURST, req_size, fifo_level;
  logic [1:0] HTRANS, ph;
  logic [31:0] wa [4];
  logic [67:0] sb [$];
  int checks = 0, errors = 0, cyc_n = 0, rsp_cyc = 0, rd_wait = 0, dc;

  ahb_slave_if_fifo dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE),
    .HSIZE(HSIZE), .HBURST(HBURST), .HTRANS(HTRANS), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .req_valid(req_valid),
    .req_ready(req_ready), .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
    .req_size(req_size), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .fifo_level(fifo_level)
  );

  assign HREADY = HREADYOUT;
  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc;
    @(posedge HCLK);
    #1;
  endtask

  task automatic ahb(input string tag, input logic [31:0] a, input logic w, input logic [2:0] sz,
                     input logic [2:0] bu, input logic [1:0] tr, input logic [1:0] tr_after,
                     input logic [31:0] wd, input logic exp_push, input logic exp_err,
                     output logic [31:0] rdv, output logic [1:0] ph1, output int done_cyc);
    logic [1:0] prev;
    logic resp;
    int n;
    HSEL = 1'b1; HADDR = a; HWRITE = w; HSIZE = sz; HBURST = bu; HTRANS = tr;
    if (exp_push) sb.push_back({a, w ? wd : 32'h0, w, sz});
    cyc;
    HTRANS = tr_after;
    HWDATA = wd;
    ph1 = {HREADYOUT, HRESP};
    prev = 2'b10;
    for (n = 0; n < 100 && !HREADYOUT; n++) begin
      prev = {HREADYOUT, HRESP};
      cyc;
    end
    if (!HREADYOUT) chk({tag, "_timeout"}, HREADYOUT, 1);
    rdv = HRDATA;
    resp = HRESP;
    done_cyc = cyc_n;
    cyc;
    chk({tag, "_resp"}, resp, exp_err);
    if (exp_err) chk({tag, "_err1"}, prev, 2'b01);
  endtask

  task automatic drain;
    req_ready = 1'b1;
    for (int n = 0; n < 50 && req_valid; n++) cyc;
    chk("drain_lvl", fifo_level, 0);
  endtask

  initial forever begin
    @(posedge HCLK);
    cyc_n++;
  end

  // APB-side model: pops against the scoreboard and answers reads a few cycles later
  initial begin
    rsp_valid = 1'b0; rsp_err = 1'b0; rsp_rdata = '0;
    forever begin
      @(negedge HCLK);
      rsp_valid = late_rsp;
      rsp_err = 1'b0;
      if (rd_wait > 0) begin
        rd_wait--;
        if (rd_wait == 0) begin
          rsp_valid = 1'b1;
          rsp_rdata = rsp_data_cfg;
          rsp_err = rsp_err_cfg;
          rsp_cyc = cyc_n;
        end
      end
      if (!HRESET && req_valid && req_ready) begin
        if (sb.size() == 0) chk("sb_extra", req_valid, 0);
        else begin
          chk("sb_head", {req_addr, req_wdata, req_write, req_size}, sb.pop_front());
          if (!req_write) rd_wait = 3;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; HSEL = 1'b0; HWRITE = 1'b0; HADDR = '0; HWDATA = '0; HSIZE = 3'd2;
    HBURST = HBURST_SINGLE; HTRANS = HTRANS_IDLE; req_ready = 1'b0; late_rsp = 1'b0;
    rsp_err_cfg = 1'b0; rsp_data_cfg = '0;
    wa = '{32'h38, 32'h3C, 32'h30, 32'h34};
    repeat (3) cyc;
    chk("rst_rdy", HREADYOUT, 1);
    chk("rst_resp", HRESP, 0);
    chk("rst_rdata", HRDATA, 0);
    chk("rst_valid", req_valid, 0);
    chk("rst_lvl", fifo_level, 0);
    HRESET = 1'b0;
    cyc;
    req_ready = 1'b1;
    ahb("t1", 32'h100, 1, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'hDEADBEEF, 1, 0, rd, ph, dc);
    chk("t1_ph1", ph, 2'b10);
    chk("t1_lvl", fifo_level, 1);
    chk("t1_head", {req_addr, req_wdata, req_write}, {32'h100, 32'hDEADBEEF, 1'b1});
    cyc;
    chk("t1_popped", fifo_level, 0);
    req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ahb("t2_incr4", 32'h200 + 32'(4 * i), 1, 2, HBURST_INCR4, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ,
          HTRANS_BUSY, 32'hA0 + 32'(i), 1, 0, rd, ph, dc);
      chk("t2_ph1", ph, 2'b10);
    end
    HTRANS = HTRANS_IDLE;
    chk("t2_lvl4", fifo_level, 4);
    fork
      begin
        repeat (4) cyc;
        req_ready = 1'b1;
        cyc;
        req_ready = 1'b0;
      end
    join_none
    ahb("t2_5th", 32'h210, 1, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'hA4, 1, 0, rd, ph, dc);
    chk("t2_stall", ph, 2'b00);
    chk("t2_lvl_after", fifo_level, 4);
    chk("t2_head_after", req_addr, 32'h204);
    drain;
    for (int i = 0; i < 4; i++)
      ahb("t3_wrap", wa[i], 1, 2, HBURST_WRAP4, i == 0 ? HTRANS_NONSEQ : HTRANS_SEQ,
          HTRANS_BUSY, 32'hB0 + 32'(i), 1, 0, rd, ph, dc);
    HTRANS = HTRANS_IDLE;
    drain;
    req_ready = 1'b0;
    ahb("t3_a", 32'h38, 1, 2, HBURST_WRAP4, HTRANS_NONSEQ, HTRANS_BUSY, 32'hC0, 1, 0, rd, ph, dc);
    ahb("t3_b", 32'h3C, 1, 2, HBURST_WRAP4, HTRANS_SEQ, HTRANS_BUSY, 32'hC1, 1, 0, rd, ph, dc);
    ahb("t3_bad", 32'h40, 1, 2, HBURST_WRAP4, HTRANS_SEQ, HTRANS_IDLE, 32'hC2, 0, 1, rd, ph, dc);
    chk("t3_lvl", fifo_level, 2);
    drain;
    req_ready = 1'b0;
    ahb("t4_w0", 32'h400, 1, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'hD0, 1, 0, rd, ph, dc);
    ahb("t4_w1", 32'h404, 1, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'hD1, 1, 0, rd, ph, dc);
    rsp_data_cfg = 32'h12345678;
    fork
      begin
        repeat (3) cyc;
        req_ready = 1'b1;
      end
    join_none
    ahb("t4_rd", 32'h300, 0, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'h0, 1, 0, rd, ph, dc);
    chk("t4_ph1", ph, 2'b00);
    chk("t4_rdata", rd, 32'h12345678);
    chk("t4_lat", dc - rsp_cyc, 1);
    rsp_err_cfg = 1'b1;
    rsp_data_cfg = 32'hFFFF0000;
    ahb("t4_rderr", 32'h304, 0, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'h0, 1, 1, rd, ph, dc);
    chk("t4_hold", rd, 32'h12345678);
    rsp_err_cfg = 1'b0;
    req_ready = 1'b0;
    ahb("t5_size", 32'h500, 1, 3'd3, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'hE0, 0, 1, rd, ph, dc);
    chk("t5_lvl", fifo_level, 0);
    ahb("t5_noburst", 32'h504, 1, 2, HBURST_INCR, HTRANS_SEQ, HTRANS_IDLE, 32'hE1, 0, 1, rd, ph, dc);
    req_ready = 1'b1;
    ahb("t5_b0", 32'h600, 1, 2, HBURST_INCR8, HTRANS_NONSEQ, HTRANS_BUSY, 32'hF0, 1, 0, rd, ph, dc);
    ahb("t5_b1", 32'h604, 1, 2, HBURST_INCR8, HTRANS_SEQ, HTRANS_BUSY, 32'hF1, 1, 0, rd, ph, dc);
    HADDR = 32'h608;
    repeat (3) cyc;
    ahb("t5_busy", 32'h608, 1, 2, HBURST_INCR8, HTRANS_SEQ, HTRANS_BUSY, 32'hF2, 1, 0, rd, ph, dc);
    ahb("t5_b3", 32'h60C, 1, 2, HBURST_INCR8, HTRANS_SEQ, HTRANS_IDLE, 32'hF3, 1, 0, rd, ph, dc);
    drain;
    req_ready = 1'b0;
    ahb("t6_w0", 32'h700, 1, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'h70, 1, 0, rd, ph, dc);
    ahb("t6_w1", 32'h704, 1, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'h71, 1, 0, rd, ph, dc);
    HADDR = 32'h708; HWRITE = 1'b0; HBURST = HBURST_SINGLE; HTRANS = HTRANS_NONSEQ;
    cyc;
    HTRANS = HTRANS_IDLE;
    repeat (3) cyc;
    chk("t6_lvl3", fifo_level, 3);
    chk("t6_wait", HREADYOUT, 0);
    HRESET = 1'b1;
    cyc;
    HRESET = 1'b0;
    sb.delete();
    chk("t6_lvl0", fifo_level, 0);
    chk("t6_rdy", HREADYOUT, 1);
    chk("t6_resp", HRESP, 0);
    chk("t6_valid", req_valid, 0);
    chk("t6_rdata", HRDATA, 0);
    late_rsp = 1'b1;
    cyc;
    late_rsp = 1'b0;
    cyc;
    chk("t6_late_rdy", HREADYOUT, 1);
    chk("t6_late_rdata", HRDATA, 0);
    req_ready = 1'b1;
    ahb("t6_after", 32'h710, 1, 2, HBURST_SINGLE, HTRANS_NONSEQ, HTRANS_IDLE, 32'h72, 1, 0, rd, ph, dc);
    chk("t6_after_ph1", ph, 2'b10);
    drain;
    cyc;
    chk("sb_left", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
